// File: rtl/cadr_msk_pkg.sv
// Shared types and constants for the CADR mask generator/encoder datapath.
package cadr_msk_pkg;

   localparam int unsigned MSK_W     = 32;
   localparam int unsigned MSK_IDX_W = 5;

   // Empty field encoding: mskr > mskl, which the generator turns into a zero mask.
   localparam logic [MSK_IDX_W-1:0] MSKL_EMPTY = 5'd0;
   localparam logic [MSK_IDX_W-1:0] MSKR_EMPTY = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mskenc_chunk.sv
// Combinational summary of one mask chunk: presence, lowest/highest set bit,
// all-ones and internal-gap flags.
module mskenc_chunk #(
   parameter int unsigned CHUNK_W = 8,
   parameter int unsigned IDX_W   = $clog2(CHUNK_W)
) (
   input  logic [CHUNK_W-1:0] chunk,
   output logic               any,
   output logic [IDX_W-1:0]   lo_idx,
   output logic [IDX_W-1:0]   hi_idx,
   output logic               all_ones,
   output logic               gap
);

   logic [CHUNK_W-1:0] w_norm;

   always_comb begin
      any      = |chunk;
      all_ones = &chunk;
      lo_idx   = '0;
      hi_idx   = '0;
      for (int i = CHUNK_W - 1; i >= 0; i--) begin
         if (chunk[i]) lo_idx = IDX_W'(i);
      end
      for (int i = 0; i < CHUNK_W; i++) begin
         if (chunk[i]) hi_idx = IDX_W'(i);
      end
      // Right-justified bits form one run iff adding 1 clears every set bit.
      w_norm = chunk >> lo_idx;
      gap    = any && ((w_norm & CHUNK_W'(w_norm + 1'b1)) != '0);
   end

endmodule

// File: rtl/mskenc4.sv
// Mask encoder: recovers mskl/mskr bounds from a 32-bit field mask, one chunk per cycle.
// Define MSKENC4_CONTIG_CHECK_EN to compile in run tracking that drives noncontig.
module mskenc4
   import cadr_msk_pkg::*;
#(
   parameter int unsigned CHUNK_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MSK_W-1:0]     msk_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [MSK_IDX_W-1:0] mskl,
   output logic [MSK_IDX_W-1:0] mskr,
   output logic                 zero,
   output logic                 noncontig
);

   localparam int unsigned NCHUNK = MSK_W / CHUNK_W;
   localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned IDX_W  = $clog2(CHUNK_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic                   r_in_ready;
   logic                   r_out_valid;
   logic [MSK_W-1:0]       r_sh;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_found;
   logic [MSK_IDX_W-1:0]   r_mskl;
   logic [MSK_IDX_W-1:0]   r_mskr;
   logic                   r_zero;
   logic                   r_noncontig;

   logic                   w_any;
   logic [IDX_W-1:0]       w_lo;
   logic [IDX_W-1:0]       w_hi;
   logic                   w_all_ones;
   logic                   w_gap;
   logic [MSK_IDX_W-1:0]   w_base;
   logic                   w_accept;

   mskenc_chunk #(
      .CHUNK_W (CHUNK_W),
      .IDX_W   (IDX_W)
   ) u_chunk (
      .chunk    (r_sh[CHUNK_W-1:0]),
      .any      (w_any),
      .lo_idx   (w_lo),
      .hi_idx   (w_hi),
      .all_ones (w_all_ones),
      .gap      (w_gap)
   );

   // Chunk base is the counter with the in-chunk index bits appended as zeros.
   assign w_base   = MSK_IDX_W'(MSK_IDX_W'(r_cnt) << IDX_W);
   assign w_accept = (r_state == ST_IDLE) && in_valid;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)           w_state_nxt = ST_SCAN;
         ST_SCAN: if (r_cnt == CNT_LAST)  w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready)          w_state_nxt = ST_IDLE;
         default:                         w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake flags track the upcoming state so they are pure register outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sh    <= '0;
         r_cnt   <= '0;
         r_found <= 1'b0;
         r_mskl  <= '0;
         r_mskr  <= '0;
         r_zero  <= 1'b0;
      end else if (w_accept) begin
         r_sh    <= msk_in;
         r_cnt   <= '0;
         r_found <= 1'b0;
         r_mskl  <= MSKL_EMPTY;
         r_mskr  <= MSKR_EMPTY;
         r_zero  <= 1'b1;
      end else if (r_state == ST_SCAN) begin
         r_sh  <= r_sh >> CHUNK_W;
         r_cnt <= CNT_W'(r_cnt + 1'b1);
         if (w_any) begin
            r_found <= 1'b1;
            r_zero  <= 1'b0;
            r_mskl  <= w_base + MSK_IDX_W'(w_hi);
            if (!r_found) r_mskr <= w_base + MSK_IDX_W'(w_lo);
         end
      end
   end

`ifdef MSKENC4_CONTIG_CHECK_EN
   logic r_open;
   logic w_unused;
   assign w_unused = w_all_ones;

   // A chunk breaks contiguity if it has an internal hole, or if an earlier run
   // did not reach the top of the previous chunk and continue from bit 0 here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_open      <= 1'b0;
         r_noncontig <= 1'b0;
      end else if (w_accept) begin
         r_open      <= 1'b0;
         r_noncontig <= 1'b0;
      end else if (r_state == ST_SCAN) begin
         if (w_any) begin
            if (w_gap || (r_found && !(r_open && (w_lo == '0)))) r_noncontig <= 1'b1;
            r_open <= (w_hi == IDX_W'(CHUNK_W - 1));
         end else begin
            r_open <= 1'b0;
         end
      end
   end
`else
   logic w_unused;
   assign w_unused    = w_all_ones ^ w_gap;
   assign r_noncontig = 1'b0;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign mskl      = r_mskl;
   assign mskr      = r_mskr;
   assign zero      = r_zero;
   assign noncontig = r_noncontig;

endmodule

// File: doc/mskenc4.md
# mskenc4

Mask encoder for the CADR byte/field datapath: the inverse of 4-bit-slice mask generation. It accepts a 32-bit field mask and recovers the left bound `mskl` (highest set bit) and the right bound `mskr` (lowest set bit). With those bounds, the mask generator's `left & right` product reproduces the input mask. The block scans the mask one chunk per cycle under a valid/ready handshake. It serves microcode-assembler cross-checks and diagnostic readback of LDB/DPB field specs.

## Interface
Parameters:
- `CHUNK_W`, default 8: bits examined per scan cycle. Legal values are 4, 8, 16 and 32. Scan length is 32/`CHUNK_W` cycles.

Ports:
- `clk`  in  1: system clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `msk_in` holds a mask to encode.
- `in_ready`  out  1: block is idle and can accept a mask.
- `msk_in`  in  32: mask to encode.
- `out_valid`  out  1: result valid; held until it is consumed.
- `out_ready`  in  1: consumer takes the result.
- `mskl`  out  5: index of the highest set bit.
- `mskr`  out  5: index of the lowest set bit.
- `zero`  out  1: the input mask was all zeros.
- `noncontig`  out  1: the set bits are not one contiguous run.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `msk_in`, clear the chunk counter, clear the found/run flags, and go to SCAN.
- SCAN:
  - Each cycle, examine chunk k = bits [k·CHUNK_W +: CHUNK_W], with k counting from 0 upward.
  - First chunk with any set bit: `mskr` ← k·CHUNK_W + index of its lowest set bit.
  - Every chunk with any set bit: `mskl` ← k·CHUNK_W + index of its highest set bit.
  - On the last chunk (k = 32/CHUNK_W−1), go to DONE.
- DONE:
  - `out_valid`=1; all result outputs are held stable.
  - On `out_ready`, go to IDLE.
- Arithmetic is 5-bit unsigned. Chunk base is the counter concatenated with zero bits; no wrap occurs.
- Zero mask: `zero`=1, `mskl`=0, `mskr`=31. This is the canonical empty field, the mskr > mskl form, whose generated mask is 0.
- Single set bit at index n: `mskl`=`mskr`=n.
- `noncontig` is computed from the full 32-bit mask. A run that crosses a chunk boundary counts as contiguous.
- `msk_in` changes while not accepted: ignored. Only the value captured at acceptance matters.

## Timing
- Reset values: state IDLE, `out_valid`=0, `mskl`=0, `mskr`=0, `zero`=0, `noncontig`=0. `in_ready`=1 from the first cycle after reset deasserts.
- `in_ready` is decoded from state only; it has no combinational path from `out_ready`.
- Latency: with acceptance at edge T, `out_valid` rises after edge T+32/CHUNK_W (T+4 with the default).
- `in_ready`=0 throughout SCAN and DONE.
- Back-to-back operation: result consumed at edge U; the next mask can be accepted at edge U+1 at the earliest. Throughput is one mask per 32/CHUNK_W+2 cycles.
- `out_ready` held low: stay in DONE indefinitely with outputs unchanged.
- Reset in any state, including mid-SCAN or in DONE before consumption: the operation is discarded, the block returns to the reset values the next cycle, and no `out_valid` pulse appears for the discarded mask.

## Configuration
- `MSKENC4_CONTIG_CHECK_EN` defined:
  - Run-tracking logic is compiled in.
  - `noncontig`=1 when any 0 bit lies between `mskr` and `mskl`.
- Macro undefined:
  - Tracking logic is absent; `noncontig` is tied to 0.
  - The port remains present, and `mskl`/`mskr`/`zero` behaviour is unchanged.

## Structure
- Shared package `cadr_msk_pkg`:
  - State enum (IDLE/SCAN/DONE).
  - `MSK_W`=32, `MSK_IDX_W`=5.
  - Canonical zero-field constants: `MSKL_EMPTY`=0, `MSKR_EMPTY`=31.
- Sub-module `mskenc_chunk`: purely combinational per-chunk summary, with outputs
  - `any`
  - `lo_idx`
  - `hi_idx`
  - `all_ones`
  - `gap` (internal 0 between set bits; used only under the macro).
- The top level holds the FSM, the chunk counter, the latched mask and the result registers.

## Test plan
- `msk_in`=0x000000FF accepted at T (default parameter) -> `out_valid` rises after edge T+4 with `mskl`=7, `mskr`=0, `zero`=0, `noncontig`=0.
- `msk_in`=0x00018000 (run crossing chunk boundary) -> `mskl`=16, `mskr`=15, `noncontig`=0. Also `msk_in`=0xFFFFFFFF -> `mskl`=31, `mskr`=0.
- `msk_in`=0x00000000 -> `zero`=1, `mskl`=0, `mskr`=31, `noncontig`=0.
- `msk_in`=0x0000F00F -> `mskl`=15, `mskr`=0, `noncontig`=1 with `MSKENC4_CONTIG_CHECK_EN` defined, 0 without.
- `out_ready`=0 for 6 cycles after `out_valid` -> outputs stable and `in_ready`=0. Then pulse `out_ready` -> IDLE, and a second mask is accepted the following cycle.
- `reset` asserted for 1 cycle at T+2 of a scan -> no `out_valid` for that mask, all outputs at reset values, `in_ready`=1 on the next cycle.
